pixel_coord_gen: RTL

Upstream stage of fullModule. Walks a raster (default 640x480) and emits one screen coordinate pair per pixel in Q11.21 on a valid/ready handshake, with sof/eol tags. A credit counter limits outstanding pixels inside the ray marcher; completions are returned from fullModule valid_out. Supports one-shot or continuous frames and a clean abort.

---
 rtl/pixel_coord_gen_pkg.sv | 23 ++
 rtl/pixel_coord_gen_raster_counter.sv | 51 +++++
 rtl/pixel_coord_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pixel_coord_gen_pkg.sv
// Shared types and helpers for the raster coordinate generator.
// Coordinates leave the block as Q11.21 fixed point.
package pixel_coord_gen_pkg;

    localparam int FRAC_Q11_21      = 21;
    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_MAX_INFLIGHT = 1;
    localparam int CREDIT_W         = 4;

    typedef logic [31:0] q11_21_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } gen_state_e;

    function automatic q11_21_t int_to_q(input logic [31:0] v, input int frac);
        return v << frac;
    endfunction

endpackage

// File: rtl/pixel_coord_gen_raster_counter.sv
// Raster walker: x/y counters with enable, clear and
// frame-position flags.
module pixel_coord_gen_raster_counter
    import pixel_coord_gen_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int XW    = $clog2(DEF_H_RES),
    parameter int YW    = $clog2(DEF_V_RES)
) (
    input  logic          clk,
    input  logic          rst_gen,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x_cnt,
    output logic [YW-1:0] y_cnt,
    output logic          last_pixel,
    output logic          sof,
    output logic          eol
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic x_last;
    logic y_last;

    assign x_last     = (x_cnt == X_LAST);
    assign y_last     = (y_cnt == Y_LAST);
    assign last_pixel = x_last & y_last;
    assign sof        = (x_cnt == '0) & (y_cnt == '0);
    assign eol        = x_last;

    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (clr) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (en) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_coord_gen.sv
// Frame sequencer: issues raster coordinates under a credit
// limit on pixels outstanding in the ray marcher.
module pixel_coord_gen
    import pixel_coord_gen_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int FRAC_BITS    = FRAC_Q11_21
) (
    input  logic        clk,
    input  logic        rst_gen,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic        pixel_done,
    input  logic        ready_in,
    output logic [31:0] screen_x,
    output logic [31:0] screen_y,
    output logic        valid_out,
    output logic        sof,
    output logic        eol,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow_err
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_INFLIGHT);

    if (H_RES > (1 << (31 - FRAC_BITS)) ||
        V_RES > (1 << (31 - FRAC_BITS))) begin : g_res_check
        $error("pixel_coord_gen: resolution exceeds coordinate range");
    end

    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_credit_check
        $error("pixel_coord_gen: MAX_INFLIGHT must be 1..15");
    end

    gen_state_e            state;
    logic                  abort_flag;
    logic [CREDIT_W-1:0]   inflight;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic                  last_pixel;
    logic                  cnt_sof;
    logic                  cnt_eol;
    logic                  fire;
    logic                  done_ok;
    logic                  drain_ok;

    // Credits and state move only on fire or state exit, so
    // valid_out and the coordinates hold until accepted.
    assign valid_out = (state == ST_ISSUE) && (inflight < CREDIT_MAX);
    assign fire      = valid_out && ready_in;
    assign done_ok   = pixel_done && (inflight != '0);
    assign drain_ok  = (inflight == '0) ||
                       ((inflight == CREDIT_W'(1)) && pixel_done);

    assign screen_x = int_to_q(32'(x_cnt), FRAC_BITS);
    assign screen_y = int_to_q(32'(y_cnt), FRAC_BITS);
    assign sof      = valid_out & cnt_sof;
    assign eol      = valid_out & cnt_eol;
    assign busy     = (state != ST_IDLE);

    pixel_coord_gen_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .clk        (clk),
        .rst_gen    (rst_gen),
        .en         (fire),
        .clr        ((state == ST_ISSUE) && abort),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .last_pixel (last_pixel),
        .sof        (cnt_sof),
        .eol        (cnt_eol)
    );

    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            inflight      <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (pixel_done && (inflight == '0))
                underflow_err <= 1'b1;
            if (fire && !done_ok)
                inflight <= inflight + CREDIT_W'(1);
            else if (!fire && done_ok)
                inflight <= inflight - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            state      <= ST_IDLE;
            abort_flag <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state      <= ST_DRAIN;
                        abort_flag <= 1'b1;
                    end else if (fire && last_pixel) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ok) begin
                        if (abort_flag || abort) begin
                            abort_flag <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= continuous ? ST_ISSUE : ST_IDLE;
                        end
                    end else if (abort) begin
                        abort_flag <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
